// File: rtl/snow64_bfloat16_vector_cast_from_int.sv
// Vector int-to-BFloat16 sequencer: feeds one integer element at a time to a
// scalar cast unit and packs the sixteen 16-bit results into a 256-bit vector.
module snow64_bfloat16_vector_cast_from_int (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_start,
  input  logic [255:0] in_to_cast,
  input  logic [1:0]   in_int_type_size,
  input  logic         in_type_signedness,
  input  logic         in_upper_half,
  output logic         out_data_valid,
  output logic         out_can_accept_cmd,
  output logic [255:0] out_data,
  output logic         out_cast_start,
  output logic [63:0]  out_cast_to_cast,
  output logic [1:0]   out_cast_int_type_size,
  output logic         out_cast_type_signedness,
  input  logic         in_cast_data_valid,
  input  logic         in_cast_can_accept_cmd,
  input  logic [15:0]  in_cast_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } state_e;

  localparam logic [1:0] SIZE_8  = 2'd0;
  localparam logic [1:0] SIZE_16 = 2'd1;
  localparam logic [1:0] SIZE_32 = 2'd2;
  localparam logic [1:0] SIZE_64 = 2'd3;

  state_e       state_q, state_d;
  logic [255:0] vec_q, vec_d;
  logic [255:0] data_q, data_d;
  logic [1:0]   size_q, size_d;
  logic         signed_q, signed_d;
  logic         upper_q, upper_d;
  logic [3:0]   idx_q, idx_d;
  logic         seen_busy_q, seen_busy_d;

  logic [3:0]   last_idx;
  logic [63:0]  elem;
  logic         accept;

  always_comb begin
    unique case (size_q)
      SIZE_32: last_idx = 4'd7;
      SIZE_64: last_idx = 4'd3;
      default: last_idx = 4'd15;
    endcase
  end

  // Upper-half selection only shifts the byte window; wider types ignore it.
  always_comb begin
    elem = '0;
    unique case (size_q)
      SIZE_8:  elem[7:0]  = vec_q[{upper_q, idx_q, 3'b000} +: 8];
      SIZE_16: elem[15:0] = vec_q[{idx_q, 4'b0000} +: 16];
      SIZE_32: elem[31:0] = vec_q[{idx_q[2:0], 5'b00000} +: 32];
      SIZE_64: elem       = vec_q[{idx_q[1:0], 6'b000000} +: 64];
      default: elem       = '0;
    endcase
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d            = state_q;
    vec_d              = vec_q;
    data_d             = data_q;
    size_d             = size_q;
    signed_d           = signed_q;
    upper_d            = upper_q;
    idx_d              = idx_q;
    seen_busy_d        = seen_busy_q;
    out_cast_start     = 1'b0;
    out_data_valid     = 1'b0;
    out_can_accept_cmd = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        out_can_accept_cmd = 1'b1;
      end
      ST_ISSUE: begin
        if (in_cast_can_accept_cmd) begin
          out_cast_start = 1'b1;
          seen_busy_d    = 1'b0;
          state_d        = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A result only counts after the unit was seen busy with our start,
        // so a valid left over from an earlier op is never taken.
        if (!in_cast_can_accept_cmd) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q && in_cast_data_valid) begin
          data_d[{idx_q, 4'b0000} +: 16] = in_cast_data;
          idx_d   = idx_q + 4'd1;
          state_d = (idx_q == last_idx) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        out_data_valid     = 1'b1;
        out_can_accept_cmd = 1'b1;
        state_d            = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    accept = in_start && out_can_accept_cmd;
    if (accept) begin
      vec_d    = in_to_cast;
      size_d   = in_int_type_size;
      signed_d = in_type_signedness;
      upper_d  = in_upper_half;
      data_d   = '0;
      idx_d    = '0;
      state_d  = ST_ISSUE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      vec_q       <= '0;
      data_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      upper_q     <= 1'b0;
      idx_q       <= '0;
      seen_busy_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      data_q      <= data_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      upper_q     <= upper_d;
      idx_q       <= idx_d;
      seen_busy_q <= seen_busy_d;
    end
  end

  assign out_data                 = data_q;
  assign out_cast_to_cast         = elem;
  assign out_cast_int_type_size   = size_q;
  assign out_cast_type_signedness = signed_q;

endmodule

// File: tb/tb_snow64_bfloat16_vector_cast_from_int.sv
// Scoreboard bench for the vector int-to-BFloat16 sequencer with a behavioural
// 2-cycle scalar cast unit (optional extra stall cycles per element).
module tb_snow64_bfloat16_vector_cast_from_int;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_start;
  logic [255:0] in_to_cast;
  logic [1:0]   in_int_type_size;
  logic         in_type_signedness;
  logic         in_upper_half;
  logic         out_data_valid;
  logic         out_can_accept_cmd;
  logic [255:0] out_data;
  logic         out_cast_start;
  logic [63:0]  out_cast_to_cast;
  logic [1:0]   out_cast_int_type_size;
  logic         out_cast_type_signedness;
  logic         in_cast_data_valid;
  logic         in_cast_can_accept_cmd;
  logic [15:0]  in_cast_data;

  always #5 clk = ~clk;

  snow64_bfloat16_vector_cast_from_int dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .in_start                 (in_start),
    .in_to_cast               (in_to_cast),
    .in_int_type_size         (in_int_type_size),
    .in_type_signedness       (in_type_signedness),
    .in_upper_half            (in_upper_half),
    .out_data_valid           (out_data_valid),
    .out_can_accept_cmd       (out_can_accept_cmd),
    .out_data                 (out_data),
    .out_cast_start           (out_cast_start),
    .out_cast_to_cast         (out_cast_to_cast),
    .out_cast_int_type_size   (out_cast_int_type_size),
    .out_cast_type_signedness (out_cast_type_signedness),
    .in_cast_data_valid       (in_cast_data_valid),
    .in_cast_can_accept_cmd   (in_cast_can_accept_cmd),
    .in_cast_data             (in_cast_data)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [255:0] data;
    int           start_cyc;
    int           lat;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] elem_q[$];
  int          extra_stall = 0;
  int          starts_m = 0;

  // Reference integer -> BFloat16 with round-to-nearest-even.
  function automatic logic [15:0] to_bf16(input logic [63:0] v, input logic [1:0] sz, input logic sg);
    logic [63:0] x, mag;
    logic        neg, guard, sticky;
    logic [7:0]  m;
    int          p, e;
    case (sz)
      2'd0:    x = sg ? {{56{v[7]}}, v[7:0]}   : {56'b0, v[7:0]};
      2'd1:    x = sg ? {{48{v[15]}}, v[15:0]} : {48'b0, v[15:0]};
      2'd2:    x = sg ? {{32{v[31]}}, v[31:0]} : {32'b0, v[31:0]};
      default: x = v;
    endcase
    neg = sg && x[63];
    mag = neg ? -x : x;
    if (mag == 64'd0) return 16'h0000;
    p = 0;
    for (int b = 0; b < 64; b++) if (mag[b]) p = b;
    if (p <= 7) begin
      m = 8'(mag << (7 - p));
      guard = 1'b0;
      sticky = 1'b0;
    end else begin
      m = 8'(mag >> (p - 7));
      guard = mag[p-8];
      sticky = (p >= 9) ? |(mag & ((64'd1 << (p - 8)) - 64'd1)) : 1'b0;
    end
    e = 127 + p;
    if (guard && (sticky || m[0])) begin
      if (m == 8'hFF) begin
        m = 8'h80;
        e++;
      end else begin
        m = m + 8'd1;
      end
    end
    return {neg, 8'(e), m[6:0]};
  endfunction

  function automatic int elem_count(input logic [1:0] sz);
    return (sz == 2'd2) ? 8 : (sz == 2'd3) ? 4 : 16;
  endfunction

  function automatic logic [63:0] elem_of(input logic [255:0] v, input logic [1:0] sz,
                                          input logic up, input int i);
    case (sz)
      2'd0:    return {56'b0, v[(up ? 128 : 0) + i*8 +: 8]};
      2'd1:    return {48'b0, v[i*16 +: 16]};
      2'd2:    return {32'b0, v[i*32 +: 32]};
      default: return v[i*64 +: 64];
    endcase
  endfunction

  function automatic logic [255:0] build_exp(input logic [255:0] v, input logic [1:0] sz,
                                             input logic sg, input logic up);
    logic [255:0] r = '0;
    for (int i = 0; i < elem_count(sz); i++) r[i*16 +: 16] = to_bf16(elem_of(v, sz, up, i), sz, sg);
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // Behavioural scalar cast unit; it never sees rst_n.
  logic        busy_m = 1'b0;
  int          cnt_m = 0;
  logic [15:0] pend_m = '0;
  always @(posedge clk) begin
    if (busy_m) begin
      if (cnt_m == 0) begin
        busy_m                 <= 1'b0;
        in_cast_can_accept_cmd <= 1'b1;
        in_cast_data_valid     <= 1'b1;
        in_cast_data           <= pend_m;
      end else begin
        cnt_m <= cnt_m - 1;
      end
    end else if (out_cast_start) begin
      check("cast_start_expected", 256'(elem_q.size() > 0), 256'(1));
      if (elem_q.size() > 0) check("cast_elem", out_cast_to_cast, elem_q.pop_front());
      starts_m               <= starts_m + 1;
      busy_m                 <= 1'b1;
      in_cast_can_accept_cmd <= 1'b0;
      in_cast_data_valid     <= 1'b0;
      cnt_m                  <= extra_stall;
      pend_m                 <= to_bf16(out_cast_to_cast, out_cast_int_type_size, out_cast_type_signedness);
    end
  end

  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n && out_data_valid) begin
      exp_t e;
      check("valid_pulse_width", 256'(prev_valid), 256'(0));
      check("valid_expected", 256'(exp_q.size() > 0), 256'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("data", out_data, e.data);
        check("latency", 256'(cyc - e.start_cyc), 256'(e.lat));
        check("can_accept_in_done", 256'(out_can_accept_cmd), 256'(1));
      end
    end
    prev_valid = out_data_valid;
  end

  // Called at a negedge with the DUT able to accept.
  task automatic issue(input logic [255:0] v, input logic [1:0] sz, input logic sg,
                       input logic up, input logic [255:0] expv);
    exp_t e;
    int   n = elem_count(sz);
    in_to_cast         = v;
    in_int_type_size   = sz;
    in_type_signedness = sg;
    in_upper_half      = up;
    in_start           = 1'b1;
    e.data      = expv;
    e.start_cyc = cyc;
    e.lat       = 3*n + 1 + n*extra_stall;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) elem_q.push_back(elem_of(v, sz, up, i));
    @(negedge clk);
    in_start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!out_can_accept_cmd && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 256'(out_can_accept_cmd), 256'(1));
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("drain_timeout", 256'(exp_q.size()), 256'(0));
    exp_q.delete();
  endtask

  task automatic wait_valid();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!out_data_valid && k < 500);
    check("valid_timeout", 256'(out_data_valid), 256'(1));
  endtask

  initial begin
    logic [255:0] v, ev, ev_s;
    int           k;
    rst_n              = 1'b0;
    in_start           = 1'b0;
    in_to_cast         = '0;
    in_int_type_size   = 2'd0;
    in_type_signedness = 1'b0;
    in_upper_half      = 1'b0;
    in_cast_data_valid     = 1'b0;
    in_cast_can_accept_cmd = 1'b1;
    in_cast_data           = '0;
    repeat (2) @(negedge clk);
    check("rst_can_accept", 256'(out_can_accept_cmd), 256'(1));
    check("rst_valid", 256'(out_data_valid), 256'(0));
    check("rst_data", out_data, 256'(0));
    check("rst_cast_start", 256'(out_cast_start), 256'(0));
    check("rst_to_cast", 256'(out_cast_to_cast), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // 64-bit signed {-1, 0, 1, 2^40}
    v = {64'h0000_0100_0000_0000, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
    issue(v, 2'd3, 1'b1, 1'b0, {192'b0, 16'h5380, 16'h3F80, 16'h0000, 16'hBF80});
    wait_drain();

    // 8-bit upper half, alternating 0x10 / 0xFF; lower half a decoy pattern
    v = '0;
    ev = '0;
    ev_s = '0;
    for (int i = 0; i < 16; i++) begin
      v[i*8 +: 8]       = 8'h55;
      v[128 + i*8 +: 8] = (i % 2 == 0) ? 8'h10 : 8'hFF;
      ev[i*16 +: 16]    = (i % 2 == 0) ? 16'h4180 : 16'h437F;
      ev_s[i*16 +: 16]  = (i % 2 == 0) ? 16'h4180 : 16'hBF80;
    end
    wait_idle();
    issue(v, 2'd0, 1'b0, 1'b1, ev);
    wait_drain();
    issue(v, 2'd0, 1'b1, 1'b1, ev_s);
    wait_drain();

    // 32-bit signed with 3 extra stall cycles per element
    extra_stall = 3;
    v = {32'h00FF_FFFF, 32'hFFFF_FF9C, 32'd100, 32'd0, 32'h8000_0000,
         32'h7FFF_FFFF, 32'd3, 32'hFFFF_FFFE};
    issue(v, 2'd2, 1'b1, 1'b0, {128'b0, 16'h4B80, 16'hC2C8, 16'h42C8, 16'h0000,
                                16'hCF00, 16'h4F00, 16'h4040, 16'hC000});
    wait_drain();
    extra_stall = 0;

    // Assorted random vectors through the reference model
    for (int t = 0; t < 4; t++) begin
      v = rand256();
      wait_idle();
      issue(v, 2'(t), 1'(t % 2), 1'b0, build_exp(v, 2'(t), 1'(t % 2), 1'b0));
      wait_drain();
    end

    // in_start during WAIT must be ignored
    v = rand256();
    issue(v, 2'd1, 1'b1, 1'b0, build_exp(v, 2'd1, 1'b1, 1'b0));
    repeat (6) @(negedge clk);
    in_to_cast = ~v;
    in_int_type_size = 2'd3;
    in_start = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    wait_drain();

    // Back-to-back: new start in the DONE cycle
    v = rand256();
    issue(v, 2'd2, 1'b0, 1'b0, build_exp(v, 2'd2, 1'b0, 1'b0));
    wait_valid();
    v = rand256();
    issue(v, 2'd3, 1'b1, 1'b0, build_exp(v, 2'd3, 1'b1, 1'b0));
    wait_drain();

    // Reset during WAIT of element 5
    v = rand256();
    k = starts_m;
    issue(v, 2'd1, 1'b0, 1'b0, build_exp(v, 2'd1, 1'b0, 1'b0));
    for (int n = 0; n < 200 && starts_m < k + 6; n++) @(negedge clk);
    check("reached_elem5", 256'(starts_m - k), 256'(6));
    rst_n = 1'b0;
    #1;
    check("abort_can_accept", 256'(out_can_accept_cmd), 256'(1));
    check("abort_valid", 256'(out_data_valid), 256'(0));
    check("abort_data", out_data, 256'(0));
    check("abort_cast_start", 256'(out_cast_start), 256'(0));
    check("abort_to_cast", 256'(out_cast_to_cast), 256'(0));
    exp_q.delete();
    elem_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", 256'(out_can_accept_cmd), 256'(1));
    v = rand256();
    v[31:0] = {16'hFFFF, 16'h0001};
    ev = build_exp(v, 2'd1, 1'b1, 1'b0);
    ev[31:0] = {16'hBF80, 16'h3F80};
    issue(v, 2'd1, 1'b1, 1'b0, ev);
    wait_drain();

    repeat (4) @(negedge clk);
    check("cast_elems_drained", 256'(elem_q.size()), 256'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
